// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame size and
// the scan codes the downstream keyboard FSM keys on.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DPS  = 2'd1,
        ST_LOAD = 2'd2
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;

endpackage

// File: rtl/ps2_clk_filter.sv
// Deglitcher for the raw PS/2 clock. The filtered level only moves once
// FILTER_LEN consecutive samples agree; fall_edge marks its 1->0 step.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  lvl_q, lvl_d;

    // Shift history and resolve the filtered level; hold while samples disagree.
    always_comb begin
        hist_d = {hist_q[FILTER_LEN-2:0], ps2c};
        lvl_d  = lvl_q;
        if (&hist_q)
            lvl_d = 1'b1;
        else if (~|hist_q)
            lvl_d = 1'b0;
        fall_edge = lvl_q & ~lvl_d;
    end

    // History and level registers; idle bus reads as all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '1;
            lvl_q  <= 1'b1;
        end else begin
            hist_q <= hist_d;
            lvl_q  <= lvl_d;
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver. Shifts one 11-bit frame per
// filtered falling edge of ps2c and presents the byte with rx_done_tick.
// Optional: define PS2_FRAME_CHECK_EN to reject frames with a bad stop
// bit or even parity (err_tick instead of rx_done_tick).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       err_tick
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    ps2_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [7:0]            dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  fall_edge;
    logic [FRAME_BITS-1:0] shift_in;
    logic                  frame_ok;
    logic                  unused_start;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .fall_edge (fall_edge)
    );

    // Start bit is only a framing marker; it is never read back.
    assign unused_start = shift_q[0];

    // Frame as it will look once the current ps2d bit is shifted in at the MSB.
    always_comb begin
        shift_in = {ps2d, shift_q[FRAME_BITS-1:1]};
`ifdef PS2_FRAME_CHECK_EN
        frame_ok = shift_in[10] & (^shift_in[9:1]);
`else
        frame_ok = 1'b1;
`endif
    end

    // Next-state, shifter, timeout and output pulses. dout and the ticks are
    // computed at the stop-bit edge so they appear registered in the load cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tmo_d   = '0;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall_edge && rx_en && !ps2d) begin
                    shift_d = shift_in;
                    cnt_d   = 4'd9;
                    state_d = ST_DPS;
                end
            end
            ST_DPS: begin
                if (fall_edge) begin
                    shift_d = shift_in;
                    if (cnt_q == 4'd0) begin
                        state_d = ST_LOAD;
                        if (frame_ok) begin
                            done_d = 1'b1;
                            dout_d = shift_in[8:1];
                        end else begin
                            err_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            shift_q <= '1;
            tmo_q   <= '0;
            dout_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tmo_q   <= tmo_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx_done_tick = done_q;
    assign err_tick     = err_q;
    assign dout         = dout_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: a bit-stream parser model predicts the ordered
// sequence of done/err events; a per-cycle compare process checks them.
module tb_ps2_frame_rx;

    localparam int FL  = 8;
    localparam int TMO = 300;

    logic       clk = 1'b0;
    logic       reset, ps2d, ps2c, rx_en;
    logic       rx_done_tick, err_tick;
    logic [7:0] dout;

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rx_en        (rx_en),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .err_tick     (err_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         checks = 0, errors = 0;
    int         done_cnt = 0, err_cnt = 0;
    logic [7:0] mdout = 8'h00;
    bit         m_busy = 0;
    int         m_nbits = 0;
    logic [9:0] m_bits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: parse the stream of sampled bits into frames.
    task automatic model_edge(input bit b, input bit en);
        bit ok;
        if (!m_busy) begin
            if (en && !b) begin
                m_busy  = 1;
                m_nbits = 0;
            end
        end else begin
            m_bits[m_nbits] = b;
            m_nbits++;
            if (m_nbits == 10) begin
                m_busy = 0;
`ifdef PS2_FRAME_CHECK_EN
                ok = m_bits[9] && (^m_bits[8:0]);
`else
                ok = 1;
`endif
                exp_q.push_back({~ok, m_bits[7:0]});
            end
        end
    endtask

    task automatic model_abort();
        if (m_busy) begin
            m_busy = 0;
            exp_q.push_back({1'b1, 8'h00});
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        exp_q.delete();
        mdout = 8'h00;
    endtask

    // Per-cycle compare against the model's event queue and held byte.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_done", {31'd0, rx_done_tick}, 0);
            chk("reset_err", {31'd0, err_tick}, 0);
            chk("reset_dout", {24'd0, dout}, 0);
        end else begin
            chk("exclusive", {31'd0, rx_done_tick & err_tick}, 0);
            if (rx_done_tick) begin
                done_cnt++;
                chk("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("done_kind", {31'd0, cur.is_err}, 0);
                    chk("done_dout", {24'd0, dout}, {24'd0, cur.data});
                    mdout = cur.data;
                end
            end else if (err_tick) begin
                err_cnt++;
                chk("err_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("err_kind", {31'd0, cur.is_err}, 1);
                end
                chk("err_dout_held", {24'd0, dout}, {24'd0, mdout});
            end else begin
                chk("dout_held", {24'd0, dout}, {24'd0, mdout});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // Drive the first n bits of frame f, half-period h clk cycles.
    task automatic send(input logic [10:0] f, input int n, input int h);
        for (int i = 0; i < n; i++) begin
            ps2d = f[i];
            wait_clk(h);
            ps2c = 1'b0;
            model_edge(f[i], rx_en);
            wait_clk(h);
            ps2c = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] d;
        bit         bad;
        int         h;
        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(3);

        // Single 0x1C frame
        send(mk(8'h1C, 0), 11, 20);
        wait_clk(30);
        chk("t1_dout", {24'd0, dout}, 32'h1C);
        chk("t1_done", done_cnt, 1);
        chk("t1_err", err_cnt, 0);

        // Key release: F0 then 1C back to back
        send(mk(BRK_F0(), 0), 11, 20);
        chk("t2_dout_f0", {24'd0, dout}, 32'hF0);
        send(mk(8'h1C, 0), 11, 20);
        wait_clk(30);
        chk("t2_dout_1c", {24'd0, dout}, 32'h1C);
        chk("t2_done", done_cnt, 3);

        // Short glitch, spurious start, frame with rx_en low: all ignored
        ps2c = 1'b0;
        wait_clk(3);
        ps2c = 1'b1;
        wait_clk(20);
        send(11'h7FF, 1, 20);
        rx_en = 1'b0;
        send(mk(8'h00, 0), 11, 15);
        rx_en = 1'b1;
        wait_clk(30);
        chk("t3_done", done_cnt, 3);
        chk("t3_err", err_cnt, 0);

        // Timeout after 5 edges, then recovery
        send(mk(8'h5A, 0), 5, 20);
        model_abort();
        wait_clk(TMO + 50);
        chk("t4_err", err_cnt, 1);
        chk("t4_dout", {24'd0, dout}, 32'h1C);
        send(mk(8'hA5, 0), 11, 20);
        wait_clk(30);
        chk("t4_recover", {24'd0, dout}, 32'hA5);

        // Bad parity on 0x1C
        send(mk(8'h1C, 1), 11, 20);
        wait_clk(30);
`ifdef PS2_FRAME_CHECK_EN
        chk("t5_dout", {24'd0, dout}, 32'hA5);
        chk("t5_err", err_cnt, 2);
`else
        chk("t5_dout", {24'd0, dout}, 32'h1C);
        chk("t5_err", err_cnt, 1);
`endif

        // Reset after 6 edges, then a clean frame
        send(mk(8'h77, 0), 6, 20);
        reset = 1'b1;
        model_reset();
        wait_clk(5);
        chk("t6_reset_dout", {24'd0, dout}, 0);
        reset = 1'b0;
        wait_clk(5);
        h = done_cnt;
        send(mk(8'h1C, 0), 11, 20);
        wait_clk(30);
        chk("t6_dout", {24'd0, dout}, 32'h1C);
        chk("t6_one_tick", done_cnt - h, 1);

        // Randomized frames, some disabled, corrupted or truncated
        for (int k = 0; k < 16; k++) begin
            d     = 8'($urandom);
            bad   = ($urandom_range(0, 3) == 0);
            h     = $urandom_range(12, 30);
            rx_en = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 6) == 0) begin
                send(mk(d, bad), $urandom_range(1, 10), h);
                model_abort();
                wait_clk(TMO + 80);
            end else begin
                send(mk(d, bad), 11, h);
            end
        end
        rx_en = 1'b1;
        wait_clk(40);
        chk("pending_events", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [7:0] BRK_F0();
        return ps2_pkg::BRK_CODE;
    endfunction

endmodule
